// File: rtl/line_cmd_queue.sv
// ---------------------------------------------------------------------------
// line_cmd_queue
//
// Command processor for the line-follower. Packed turn-sequence commands
// from the UART wrapper are queued in a small FIFO. They are then executed
// one two-bit step at a time against the line sensor. The block drives the
// motor enable and the signed heading error into the PID/motor path.
//
// Step codes (LSB pair first): 00 end, 01 veer right, 10 veer left,
// 11 reverse (two timed phases, then settle until the line is found).
//
// Ports
//   clk           system clock, all state on rising edge
//   rst_n         asynchronous active-low reset
//   cmd           command word from the UART wrapper (CMD_W bits)
//   cmd_rdy       cmd valid, held by the wrapper until cleared
//   clr_cmd_rdy   accept strobe back to the wrapper (combinational)
//   line_present  line sensor sees tape
//   BMPL_n/BMPR_n bump switches, active low, already synchronised
//   go            motors enabled
//   err_opn_lp    signed heading error
//   buzz          buzzer drive
//   q_cnt         FIFO occupancy
//
// Configuration macro: LCQ_BUZZ_EN
//   defined   : buzzer counter present, buzz = counter[BUZZ_BIT]
//   undefined : no counter, buzz tied low (debounce/hold unchanged)
// ---------------------------------------------------------------------------
module line_cmd_queue #(
    parameter int          CMD_W    = 16,
    parameter int          DEPTH    = 4,
    parameter logic [15:0] VEER_MAG = 16'h0340,
    parameter logic [15:0] REV1_MAG = 16'h01E0,
    parameter logic [15:0] REV2_MAG = 16'h0380,
    parameter logic [25:0] REV1_CYC = 26'd1441792,
    parameter logic [25:0] REV2_CYC = 26'd65011712,
    parameter logic [25:0] DBNC_CYC = 26'd4194304,
    parameter int          BUZZ_BIT = 14
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CMD_W-1:0]         cmd,
    input  logic                     cmd_rdy,
    output logic                     clr_cmd_rdy,
    input  logic                     line_present,
    input  logic                     BMPL_n,
    input  logic                     BMPR_n,
    output logic                     go,
    output logic [15:0]              err_opn_lp,
    output logic                     buzz,
    output logic [$clog2(DEPTH):0]   q_cnt
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        FOLLOW,
        VEER,
        REV1,
        REV2,
        SETTLE,
        DBNC,
        HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [CMD_W-1:0]   sreg_q, sreg_d;
    logic               last_right_q, last_right_d;
    logic [25:0]        timer_q, timer_d, timer_inc;

    logic [CMD_W-1:0]   mem_q [DEPTH];
    logic [CMD_W-1:0]   mem_d [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        cnt_q, cnt_d;

    logic               push;
    logic               pop;
    logic [1:0]         step;
    logic               bump;
    logic               released;

    // Full is judged on the registered count, so a pop in this cycle does
    // not free a slot until the next one. Gating with rst_n keeps the
    // strobe low while the block is held in reset.
    assign push        = rst_n && cmd_rdy && (cnt_q != FULL_CNT);
    assign clr_cmd_rdy = push;
    assign q_cnt       = cnt_q;

    assign step      = sreg_q[1:0];
    assign bump      = !BMPL_n || !BMPR_n;
    assign released  = BMPL_n && BMPR_n;
    // The timer saturates so a long stay in any state can never wrap it
    // back onto a compare value.
    assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 26'd1;

    // FIFO bookkeeping: write at wr_ptr, read at rd_ptr, count tracks both.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = cmd;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Next-state logic. A step advance shifts the active command right by
    // one pair and remembers which way the completed step pointed, so a
    // later reverse knows which side to back out on.
    always_comb begin
        state_d      = state_q;
        sreg_d       = sreg_q;
        last_right_d = last_right_q;
        timer_d      = timer_inc;
        pop          = 1'b0;
        case (state_q)
            IDLE: begin
                if ((cnt_q != '0) && line_present) begin
                    pop     = 1'b1;
                    sreg_d  = mem_q[rd_ptr_q];
                    state_d = FOLLOW;
                end
            end
            FOLLOW: begin
                if (bump) begin
                    timer_d = '0;
                    state_d = DBNC;
                end else if (!line_present) begin
                    case (step)
                        2'b00:   state_d = IDLE;
                        2'b11: begin
                            timer_d = '0;
                            state_d = REV1;
                        end
                        default: state_d = VEER;
                    endcase
                end
            end
            VEER: begin
                if (line_present) begin
                    sreg_d       = sreg_q >> 2;
                    last_right_d = sreg_q[0];
                    state_d      = FOLLOW;
                end
            end
            REV1: begin
                if (timer_q == REV1_CYC - 26'd1) begin
                    timer_d = '0;
                    state_d = REV2;
                end
            end
            REV2: begin
                if (timer_q == REV2_CYC - 26'd1) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (line_present) begin
                    sreg_d       = sreg_q >> 2;
                    last_right_d = sreg_q[0];
                    state_d      = FOLLOW;
                end
            end
            DBNC: begin
                if (timer_q == DBNC_CYC - 26'd1) begin
                    state_d = released ? FOLLOW : HOLD;
                end
            end
            HOLD: begin
                if (released) begin
                    state_d = FOLLOW;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore output decode. Reverse backs out opposite to the last veer,
    // then swings the other way to recentre over the line.
    always_comb begin
        go         = 1'b0;
        err_opn_lp = 16'h0000;
        case (state_q)
            FOLLOW: go = 1'b1;
            VEER: begin
                go = 1'b1;
                if (step == 2'b01) begin
                    err_opn_lp = VEER_MAG;
                end else if (step == 2'b10) begin
                    err_opn_lp = -VEER_MAG;
                end
            end
            REV1: begin
                go         = 1'b1;
                err_opn_lp = last_right_q ? REV1_MAG : -REV1_MAG;
            end
            REV2: begin
                go         = 1'b1;
                err_opn_lp = last_right_q ? -REV2_MAG : REV2_MAG;
            end
            SETTLE: go = 1'b1;
            default: begin
                go         = 1'b0;
                err_opn_lp = 16'h0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sreg_q       <= '0;
            last_right_q <= 1'b0;
            timer_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            sreg_q       <= sreg_d;
            last_right_q <= last_right_d;
            timer_q      <= timer_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

`ifdef LCQ_BUZZ_EN
    logic [BUZZ_BIT:0] buzz_cnt_q, buzz_cnt_d;

    // The buzzer counter only runs while stopped on a bump and keeps its
    // value otherwise, so the tone phase carries over between bumps.
    always_comb begin
        buzz_cnt_d = buzz_cnt_q;
        if ((state_q == DBNC) || (state_q == HOLD)) begin
            buzz_cnt_d = buzz_cnt_q + (BUZZ_BIT+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buzz_cnt_q <= '0;
        end else begin
            buzz_cnt_q <= buzz_cnt_d;
        end
    end

    assign buzz = buzz_cnt_q[BUZZ_BIT];
`else
    // No buzzer hardware in this build; BUZZ_BIT is never negative, so
    // this is constant low.
    assign buzz = (BUZZ_BIT < 0);
`endif

endmodule

// File: tb/tb_line_cmd_queue.sv
// ---------------------------------------------------------------------------
// tb_line_cmd_queue
//
// Self-checking bench for line_cmd_queue with short timer parameters.
// The reference is a plain step-list walk of each command plus a queue of
// pending commands, a running buzzer clock count, and the last-veer flag.
// ---------------------------------------------------------------------------
module tb_line_cmd_queue;

    localparam int          CMD_W    = 16;
    localparam int          DEPTH    = 4;
    localparam int          BUZZ_BIT = 2;
    localparam int          REV1     = 10;
    localparam int          REV2     = 20;
    localparam int          DBNC     = 8;
    localparam logic [15:0] VEER     = 16'h0340;
    localparam logic [15:0] R1       = 16'h01E0;
    localparam logic [15:0] R2       = 16'h0380;

    logic                   clk;
    logic                   rst_n;
    logic [CMD_W-1:0]       cmd;
    logic                   cmd_rdy;
    logic                   clr_cmd_rdy;
    logic                   line_present;
    logic                   BMPL_n;
    logic                   BMPR_n;
    logic                   go;
    logic [15:0]            err_opn_lp;
    logic                   buzz;
    logic [$clog2(DEPTH):0] q_cnt;

    int                     checks = 0;
    int                     errors = 0;
    logic [15:0]            q_model [$];
    logic                   lr;
    int                     bz;
    logic [15:0]            act;

    line_cmd_queue #(
        .CMD_W    (CMD_W),
        .DEPTH    (DEPTH),
        .VEER_MAG (VEER),
        .REV1_MAG (R1),
        .REV2_MAG (R2),
        .REV1_CYC (26'd10),
        .REV2_CYC (26'd20),
        .DBNC_CYC (26'd8),
        .BUZZ_BIT (BUZZ_BIT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd          (cmd),
        .cmd_rdy      (cmd_rdy),
        .clr_cmd_rdy  (clr_cmd_rdy),
        .line_present (line_present),
        .BMPL_n       (BMPL_n),
        .BMPR_n       (BMPR_n),
        .go           (go),
        .err_opn_lp   (err_opn_lp),
        .buzz         (buzz),
        .q_cnt        (q_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] neg16(input logic [15:0] v);
        return 16'h0000 - v;
    endfunction

    function automatic logic expBuzz();
`ifdef LCQ_BUZZ_EN
        return bz[BUZZ_BIT];
`else
        return 1'b0;
`endif
    endfunction

    // Random command: steps 01/10 common, 11 rare; after the terminating 00
    // the upper pairs may hold garbage that must never execute.
    function automatic logic [15:0] randCmd();
        logic [15:0] c = 16'h0000;
        bit          done = 1'b0;
        int          r;
        for (int k = 0; k < CMD_W/2; k++) begin
            r = $urandom_range(0, 9);
            if (done) begin
                c[2*k +: 2] = 2'($urandom_range(0, 3));
            end else if (r == 0) begin
                done = 1'b1;
            end else begin
                c[2*k +: 2] = (r <= 4) ? 2'b01 : ((r <= 8) ? 2'b10 : 2'b11);
            end
        end
        return c;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkMotion(input string tag, input logic g, input logic [15:0] e);
        checkOutput({tag, "_go"}, {31'd0, go}, {31'd0, g});
        checkOutput({tag, "_err"}, {16'd0, err_opn_lp}, {16'd0, e});
    endtask

    task automatic applyStimulus(input logic [15:0] c, input logic rdy, input logic lp,
                                 input logic bl, input logic br);
        cmd          = c;
        cmd_rdy      = rdy;
        line_present = lp;
        BMPL_n       = bl;
        BMPR_n       = br;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pushCmd(input logic [15:0] c);
        cmd     = c;
        cmd_rdy = 1'b1;
        #1;
        checkOutput("clr_strobe", {31'd0, clr_cmd_rdy}, 32'd1);
        q_model.push_back(c);
        tick();
        cmd_rdy = 1'b0;
        #1;
        checkOutput("clr_released", {31'd0, clr_cmd_rdy}, 32'd0);
        checkOutput("q_cnt_push", 32'(q_cnt), 32'(q_model.size()));
    endtask

    task automatic startRun(output logic [15:0] a);
        line_present = 1'b1;
        tick();
        a = q_model.pop_front();
        checkMotion("pop_follow", 1'b1, 16'h0000);
        checkOutput("q_cnt_pop", 32'(q_cnt), 32'(q_model.size()));
    endtask

    // Walk the command's steps in order; a fully consumed word reads as 00.
    task automatic runActive(input logic [15:0] c);
        logic [1:0]  st;
        logic [15:0] e;
        for (int k = 0; k <= CMD_W/2; k++) begin
            st = (k < CMD_W/2) ? c[2*k +: 2] : 2'b00;
            repeat ($urandom_range(0, 2)) begin
                tick();
                checkMotion("follow_hold", 1'b1, 16'h0000);
            end
            line_present = 1'b0;
            tick();
            if (st == 2'b00) begin
                checkMotion("end_idle", 1'b0, 16'h0000);
                break;
            end else if (st != 2'b11) begin
                e = (st == 2'b01) ? VEER : neg16(VEER);
                checkMotion("veer", 1'b1, e);
                repeat ($urandom_range(0, 2)) begin
                    tick();
                    checkMotion("veer_hold", 1'b1, e);
                end
                line_present = 1'b1;
                tick();
                checkMotion("veer_back", 1'b1, 16'h0000);
                lr = st[0];
            end else begin
                for (int i = 0; i < REV1; i++) begin
                    if (i > 0) tick();
                    checkMotion("rev1", 1'b1, lr ? R1 : neg16(R1));
                end
                for (int i = 0; i < REV2; i++) begin
                    tick();
                    checkMotion("rev2", 1'b1, lr ? neg16(R2) : R2);
                end
                tick();
                checkMotion("settle", 1'b1, 16'h0000);
                repeat ($urandom_range(0, 2)) begin
                    tick();
                    checkMotion("settle_hold", 1'b1, 16'h0000);
                end
                line_present = 1'b1;
                tick();
                checkMotion("settle_back", 1'b1, 16'h0000);
                lr = 1'b1;
            end
        end
    endtask

    // Motors stay off for the longer of the debounce window and the press.
    task automatic bumpEpisode(input int len, input bit right);
        int n;
        n = (len > DBNC) ? len : DBNC;
        if (right) BMPR_n = 1'b0;
        else       BMPL_n = 1'b0;
        for (int s = 1; s <= n; s++) begin
            tick();
            checkMotion("bump_stop", 1'b0, 16'h0000);
            checkOutput("bump_buzz", {31'd0, buzz}, {31'd0, expBuzz()});
            if (s == len) begin
                BMPL_n = 1'b1;
                BMPR_n = 1'b1;
            end
            bz++;
        end
        tick();
        checkMotion("bump_resume", 1'b1, 16'h0000);
        checkOutput("buzz_frozen", {31'd0, buzz}, {31'd0, expBuzz()});
    endtask

    initial begin
        rst_n = 1'b0;
        lr    = 1'b0;
        bz    = 0;
        applyStimulus(16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);

        tick();
        checkMotion("reset", 1'b0, 16'h0000);
        checkOutput("reset_buzz", {31'd0, buzz}, 32'd0);
        checkOutput("reset_q_cnt", 32'(q_cnt), 32'd0);
        checkOutput("reset_clr", {31'd0, clr_cmd_rdy}, 32'd0);
        rst_n = 1'b1;

        pushCmd(16'h0009);
        startRun(act);
        runActive(act);

        repeat (4) begin
            pushCmd(randCmd());
            pushCmd(randCmd());
            startRun(act);
            runActive(act);
            startRun(act);
            runActive(act);
        end

        pushCmd(16'h0001);
        startRun(act);
        bumpEpisode(3, 1'b0);
        bumpEpisode(20, 1'b0);
        bumpEpisode($urandom_range(1, 20), 1'b1);

        line_present = 1'b0;
        tick();
        checkMotion("veer_bump_in", 1'b1, VEER);
        BMPL_n = 1'b0;
        tick();
        checkMotion("veer_bump_ign", 1'b1, VEER);
        tick();
        checkMotion("veer_bump_ign2", 1'b1, VEER);
        BMPL_n       = 1'b1;
        line_present = 1'b1;
        tick();
        checkMotion("veer_bump_back", 1'b1, 16'h0000);
        lr           = 1'b1;
        line_present = 1'b0;
        tick();
        checkMotion("bump_cmd_end", 1'b0, 16'h0000);
        BMPR_n = 1'b0;
        tick();
        tick();
        checkMotion("idle_bump_ign", 1'b0, 16'h0000);
        checkOutput("idle_bump_buzz", {31'd0, buzz}, {31'd0, expBuzz()});
        BMPR_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) begin
            pushCmd((i == 0) ? 16'h000D : 16'($urandom));
        end
        cmd     = 16'h1234;
        cmd_rdy = 1'b1;
        #1;
        checkOutput("full_no_strobe", {31'd0, clr_cmd_rdy}, 32'd0);
        repeat (3) begin
            tick();
            checkOutput("full_hold_clr", {31'd0, clr_cmd_rdy}, 32'd0);
            checkOutput("full_q_cnt", 32'(q_cnt), 32'(DEPTH));
        end
        line_present = 1'b1;
        tick();
        act = q_model.pop_front();
        checkOutput("pop_frees_slot", 32'(q_cnt), 32'(DEPTH - 1));
        checkOutput("late_strobe", {31'd0, clr_cmd_rdy}, 32'd1);
        checkMotion("full_pop_follow", 1'b1, 16'h0000);
        tick();
        q_model.push_back(16'h1234);
        checkOutput("strobe_one_cycle", {31'd0, clr_cmd_rdy}, 32'd0);
        checkOutput("refill_q_cnt", 32'(q_cnt), 32'(q_model.size()));
        cmd_rdy = 1'b0;

        line_present = 1'b0;
        tick();
        checkMotion("f_veer", 1'b1, VEER);
        line_present = 1'b1;
        tick();
        checkMotion("f_back", 1'b1, 16'h0000);
        lr           = 1'b1;
        line_present = 1'b0;
        tick();
        checkMotion("f_rev1", 1'b1, R1);
        repeat (REV1 - 1 + 5) tick();
        checkMotion("f_rev2", 1'b1, neg16(R2));

        cmd     = 16'h0006;
        cmd_rdy = 1'b1;
        #1;
        checkOutput("pend_full", {31'd0, clr_cmd_rdy}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        q_model.delete();
        lr = 1'b0;
        bz = 0;
        checkMotion("async_rst", 1'b0, 16'h0000);
        checkOutput("async_rst_buzz", {31'd0, buzz}, 32'd0);
        checkOutput("async_rst_q_cnt", 32'(q_cnt), 32'd0);
        checkOutput("async_rst_clr", {31'd0, clr_cmd_rdy}, 32'd0);
        tick();
        tick();
        checkOutput("rst_held_q_cnt", 32'(q_cnt), 32'd0);
        checkOutput("rst_held_clr", {31'd0, clr_cmd_rdy}, 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("reaccept_strobe", {31'd0, clr_cmd_rdy}, 32'd1);
        q_model.push_back(16'h0006);
        tick();
        cmd_rdy = 1'b0;
        #1;
        checkOutput("reaccept_q_cnt", 32'(q_cnt), 32'd1);

        cmd          = 16'h0001;
        cmd_rdy      = 1'b1;
        line_present = 1'b1;
        #1;
        checkOutput("pushpop_strobe", {31'd0, clr_cmd_rdy}, 32'd1);
        tick();
        act = q_model.pop_front();
        q_model.push_back(16'h0001);
        cmd_rdy = 1'b0;
        checkOutput("pushpop_q_cnt", 32'(q_cnt), 32'(q_model.size()));
        checkMotion("pushpop_follow", 1'b1, 16'h0000);
        runActive(act);
        startRun(act);
        runActive(act);
        checkOutput("final_q_cnt", 32'(q_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_cmd_queue.md
# line_cmd_queue

Parametrised command processor for the line-follower: accepts 16-bit (generally `CMD_W`-bit) packed turn-sequence commands from the UART wrapper into a small FIFO. It executes them step by step against `line_present`, driving `go` and the heading error `err_opn_lp` into the PID/motor path. Adds to the previous generation: queued commands, parameter-driven magnitudes and timer thresholds, a counted bump debounce, and an explicit stop/end step. Sits between `UART_wrapper` and the steering controller.

## Interface
- `CMD_W`, 16, command width; even, ≥4; holds `CMD_W/2` two-bit steps, LSB pair first
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `VEER_MAG`, 16'h0340, error magnitude while veering
- `REV1_MAG`, 16'h01E0, error magnitude, reverse phase 1
- `REV2_MAG`, 16'h0380, error magnitude, reverse phase 2 (opposite sign to phase 1)
- `REV1_CYC`, 26'd1441792, phase-1 duration in clocks
- `REV2_CYC`, 26'd65011712, phase-2 duration in clocks
- `DBNC_CYC`, 26'd4194304, bump debounce window in clocks
- `BUZZ_BIT`, 14, buzzer counter bit driven to `buzz`
- `clk` in 1: system clock, all state on rising edge
- `rst_n` in 1: asynchronous active-low reset
- `cmd` in `CMD_W`: command word from UART wrapper
- `cmd_rdy` in 1: `cmd` valid, held until cleared
- `clr_cmd_rdy` out 1: one-cycle accept strobe to UART wrapper
- `line_present` in 1: line sensor sees tape
- `BMPL_n`, `BMPR_n` in 1: bump switches, active low, already synchronised
- `go` out 1: motors enabled
- `err_opn_lp` out 16: signed two's-complement heading error
- `buzz` out 1: buzzer drive
- `q_cnt` out `$clog2(DEPTH)+1`: FIFO occupancy

## Operation
- Step codes: 00 end-of-command, 01 veer right (+`VEER_MAG`), 10 veer left (−`VEER_MAG`), 11 reverse.
- FIFO push: `cmd_rdy && q_cnt<DEPTH` → write `cmd`, `clr_cmd_rdy`=1 same cycle. When full, no strobe; `cmd_rdy` stays pending.
- Full/empty are judged on the registered `q_cnt`; push and pop in the same cycle are both allowed when 0<`q_cnt`<`DEPTH`, and `q_cnt` is unchanged.
- Shift register `sreg` (`CMD_W` bits) holds the active command. A step advance shifts right by 2 and zero-fills. `last_right` captures `sreg[0]` on every advance (reset 0).
- States:
  - IDLE: `go`=0, err 0. If `q_cnt`>0 && `line_present`: pop into `sreg` → FOLLOW.
  - FOLLOW: `go`=1, err 0. Bump (either `_n` low) → clear timer → DBNC. Else `!line_present`: step 00 → IDLE; 01/10 → VEER; 11 → clear timer → REV1.
  - VEER: `go`=1, err ±`VEER_MAG` per step; on `line_present`, advance → FOLLOW.
  - REV1: `go`=1, err −`REV1_MAG` if `last_right`=0 else +`REV1_MAG`. When timer = `REV1_CYC`−1: clear timer → REV2.
  - REV2: `go`=1, err +`REV2_MAG` if `last_right`=0 else −`REV2_MAG`. When timer = `REV2_CYC`−1 → SETTLE.
  - SETTLE: `go`=1, err 0; on `line_present`, advance → FOLLOW.
  - DBNC: `go`=0, buzzer on. When timer = `DBNC_CYC`−1: both released → FOLLOW, else → HOLD.
  - HOLD: `go`=0, buzzer on; both released → FOLLOW.
- Bumps are ignored outside FOLLOW.
- Buzzer counter runs only in DBNC/HOLD; it freezes (not cleared) elsewhere. `buzz` = counter[`BUZZ_BIT`].
- Timer is 26 bits and saturates at all-ones, so it never wraps.

## Timing
- Reset values: state IDLE, `go`=0, `err_opn_lp`=0, `buzz`=0, `q_cnt`=0, `clr_cmd_rdy`=0, `sreg`=0, timer 0, `last_right`=0.
- `go` and `err_opn_lp` are Moore-decoded from the registered state and `sreg`; they change one cycle after the causing input.
- `clr_cmd_rdy` is combinational from `cmd_rdy` and `q_cnt`. The FIFO write lands on the same edge.
- Pop-to-FOLLOW takes 1 cycle. A fully consumed command leaves `sreg`=0, which decodes as step 00 and ends the run at the next line loss.
- Reset mid-operation returns to the reset values immediately, including FIFO flush; a pending `cmd_rdy` is re-accepted after release.

## Configuration
- `LCQ_BUZZ_EN` defined: buzzer counter present, behaviour as above.
- `LCQ_BUZZ_EN` undefined: counter removed, `buzz` tied 0. Debounce and HOLD behaviour are unchanged.

## Test plan
- Push 16'h0009 (steps 01,10) with `line_present`=1 → `clr_cmd_rdy` pulse, `q_cnt` 1→0, FOLLOW. Line drop → err 16'h0340; line returns → 0. Next drop → 16'hFCC0. Third drop → IDLE, `go`=0.
- Send DEPTH+1 commands while in IDLE with `line_present`=0 → `q_cnt`=DEPTH. Last `cmd_rdy` gets no strobe until one pop occurs, then 1-cycle strobe.
- Step 01 then 11 with small `REV1_CYC`=10, `REV2_CYC`=20 → err +16'h01E0 for 10 clocks, −16'h0380 for 20 clocks, then 0 until `line_present`.
- `DBNC_CYC`=8, `BMPL_n` low 3 clocks in FOLLOW → `go`=0 for 8 clocks, then FOLLOW. Held 20 clocks → HOLD until release. `buzz` toggles per `BUZZ_BIT`=2 when `LCQ_BUZZ_EN` set; `buzz` stays 0 when it is not set.
- Assert `rst_n` low during REV2 with `q_cnt`=2 → all outputs and `q_cnt` at 0 asynchronously.
